// File: rtl/regfile_write_arbiter_if.sv
// Purpose: writeback requester bus plus register-file write port of regfile_write_arbiter.
// Latency: none, signal bundle only.
// Backpressure: req_ready is the per-requester grant; requesters hold valid and payload until granted.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef NUM_REGS_WIDTH
`define NUM_REGS_WIDTH 4
`endif
`ifndef NUM_REGS
`define NUM_REGS 16
`endif

interface regfile_write_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int WORD_W = `WORD_WIDTH,
  parameter int RIDX_W = `NUM_REGS_WIDTH
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*RIDX_W-1:0] req_rd;
  logic [N_REQ*WORD_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    write_en;
  logic [RIDX_W-1:0]       wr_rd;
  logic [WORD_W-1:0]       wr_data;
  logic                    clear_done;

  // Requester / register-file side.
  modport master (
    output req_valid, req_rd, req_data,
    input  req_ready, write_en, wr_rd, wr_data, clear_done
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_rd, req_data,
    output req_ready, write_en, wr_rd, wr_data, clear_done
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Purpose: round-robin share of the register-file write port, after a reset-time clear of all registers.
// Latency: grant is combinational; the write port is driven on the cycle after the handshake.
// Backpressure: req_ready stays 0 during clear; in RUN one valid requester per cycle is granted.
// Optional feature: define REG_ZERO_GUARD_EN to swallow writes to register 0 while running.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef NUM_REGS_WIDTH
`define NUM_REGS_WIDTH 4
`endif
`ifndef NUM_REGS
`define NUM_REGS 16
`endif

module regfile_write_arbiter #(
  parameter int N_REQ  = 3,
  parameter int WORD_W = `WORD_WIDTH,
  parameter int RIDX_W = `NUM_REGS_WIDTH,
  parameter int NREGS  = `NUM_REGS
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // One extra bit so that NREGS == 2**RIDX_W still reaches its last index cleanly.
  localparam logic [RIDX_W:0]  CLR_LAST = (RIDX_W+1)'(NREGS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  logic [RIDX_W:0]   clr_idx;
  logic [PTR_W-1:0]  rr_ptr;
  logic              write_en;
  logic [RIDX_W-1:0] wr_rd;
  logic [WORD_W-1:0] wr_data;
  logic              clear_done;

  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  cand;
  logic              gnt_any;
  logic [RIDX_W-1:0] gnt_rd;
  logic [WORD_W-1:0] gnt_data;
  logic              blocked;

  // Round-robin search starting at rr_ptr; scanning from the farthest offset down
  // lets the nearest valid requester overwrite earlier candidates.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    cand     = '0;
    gnt_any  = 1'b0;
    gnt_rd   = '0;
    gnt_data = '0;
    if (state == RUN) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        cand = PTR_W'((int'(rr_ptr) + k) % N_REQ);
        if (bus.req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) begin
      grant = N_REQ'(1) << gnt_idx;
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        gnt_rd   = bus.req_rd[k*RIDX_W +: RIDX_W];
        gnt_data = bus.req_data[k*WORD_W +: WORD_W];
      end
    end
  end

  // Writes to r0 are accepted but dropped when the zero guard is built in.
`ifdef REG_ZERO_GUARD_EN
  assign blocked = (gnt_rd == '0);
`else
  assign blocked = 1'b0;
`endif

  // Control FSM: clear walk, then arbitration; all write-port outputs registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      rr_ptr     <= '0;
      write_en   <= 1'b0;
      wr_rd      <= '0;
      wr_data    <= '0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          write_en <= 1'b1;
          wr_rd    <= clr_idx[RIDX_W-1:0];
          wr_data  <= '0;
          clr_idx  <= clr_idx + 1'b1;
          if (clr_idx == CLR_LAST) begin
            state      <= RUN;
            clear_done <= 1'b1;
          end
        end
        RUN: begin
          if (gnt_any) begin
            rr_ptr <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
            if (!blocked) begin
              write_en <= 1'b1;
              wr_rd    <= gnt_rd;
              wr_data  <= gnt_data;
            end else begin
              write_en <= 1'b0;
            end
          end else begin
            write_en <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.req_ready  = grant;
  assign bus.write_en   = write_en;
  assign bus.wr_rd      = wr_rd;
  assign bus.wr_data    = wr_data;
  assign bus.clear_done = clear_done;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose: directed plus randomized bench for regfile_write_arbiter against a write-stream model.
// Latency: model predicts the write port one cycle after each handshake.
// Backpressure: requesters hold valid and payload until they see their ready bit.
module tb_regfile_write_arbiter;
  localparam int N     = 3;
  localparam int W     = 32;
  localparam int R     = 4;
  localparam int NREGS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]   vld  = '0;
  logic [N*R-1:0] rdv  = '0;
  logic [N*W-1:0] datv = '0;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_write_arbiter_if #(.N_REQ(N), .WORD_W(W), .RIDX_W(R)) bus ();

  assign bus.req_valid = vld;
  assign bus.req_rd    = rdv;
  assign bus.req_data  = datv;

  regfile_write_arbiter #(.N_REQ(N), .WORD_W(W), .RIDX_W(R), .NREGS(NREGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Registers block stand-in, fed only by the DUT write port.
  logic [W-1:0] sh_regs [NREGS];
  always @(posedge clk) begin
    if (bus.write_en) sh_regs[bus.wr_rd] <= bus.wr_data;
  end

  // Behavioural model: a pending clear walk, a round-robin pointer, and the next write-port value.
  bit           m_clear;
  int           m_cnt;
  int           m_ptr;
  bit           m_we;
  logic [R-1:0] m_rd;
  logic [W-1:0] m_data;
  bit           m_done;
  logic [W-1:0] m_regs [NREGS];
  logic [N-1:0] last_rdy = '0;

  always @(negedge clk) begin
    int best, bestd, d;
    logic [N-1:0] exp_rdy;
    logic [R-1:0] g_rd;
    if (!rst) begin
      check("rst_we",   bus.write_en,   0);
      check("rst_rd",   bus.wr_rd,      0);
      check("rst_data", bus.wr_data,    0);
      check("rst_done", bus.clear_done, 0);
      check("rst_rdy",  bus.req_ready,  0);
      m_clear = 1; m_cnt = 0; m_ptr = 0; m_we = 0; m_rd = '0; m_data = '0; m_done = 0;
      last_rdy = '0;
    end else begin
      // Grant = valid requester at the smallest cyclic distance past the pointer.
      best = -1; bestd = N; exp_rdy = '0;
      if (!m_clear) begin
        for (int i = 0; i < N; i++) begin
          d = (i - m_ptr + N) % N;
          if (vld[i] && d < bestd) begin best = i; bestd = d; end
        end
        if (best >= 0) exp_rdy[best] = 1'b1;
      end
      check("m_rdy",  bus.req_ready,  exp_rdy);
      check("m_we",   bus.write_en,   m_we);
      check("m_rd",   bus.wr_rd,      m_rd);
      check("m_data", bus.wr_data,    m_data);
      check("m_done", bus.clear_done, m_done);
      last_rdy = bus.req_ready;
      if (m_clear) begin
        m_we = 1; m_rd = R'(m_cnt); m_data = '0; m_regs[m_cnt] = '0;
        m_cnt++;
        if (m_cnt == NREGS) begin m_clear = 0; m_done = 1; end
      end else if (best >= 0) begin
        g_rd = rdv[best*R +: R];
        m_ptr = (best + 1) % N;
`ifdef REG_ZERO_GUARD_EN
        if (g_rd == '0) begin
          m_we = 0;
        end else begin
          m_we = 1; m_rd = g_rd; m_data = datv[best*W +: W]; m_regs[g_rd] = m_data;
        end
`else
        m_we = 1; m_rd = g_rd; m_data = datv[best*W +: W]; m_regs[g_rd] = m_data;
`endif
      end else begin
        m_we = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [R-1:0] r, input logic [W-1:0] dt);
    rdv[i*R +: R]  = r;
    datv[i*W +: W] = dt;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] g3 [6];

  initial begin
    g3[0] = 3'b001; g3[1] = 3'b010; g3[2] = 3'b100;
    g3[3] = 3'b001; g3[4] = 3'b010; g3[5] = 3'b100;

    // Clear walk with every requester asking throughout.
    set_req(0, 4'd1, 32'h11); set_req(1, 4'd2, 32'h22); set_req(2, 4'd3, 32'h33);
    vld = 3'b111;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NREGS; k++) begin
      @(negedge clk);
      check("clr_we",   bus.write_en,   1);
      check("clr_rd",   bus.wr_rd,      k);
      check("clr_data", bus.wr_data,    0);
      check("clr_rdy",  bus.req_ready,  0);
      check("clr_done", bus.clear_done, (k == NREGS - 1));
      if (k == NREGS - 2) begin step(); vld = '0; end
    end
    @(negedge clk);
    check("post_clr_we", bus.write_en, 0);

    // Lone requester 1.
    step(); set_req(1, 4'd5, 32'hBEEF); vld = 3'b010;
    @(negedge clk); check("t2_rdy", bus.req_ready, 3'b010);
    step(); vld = '0;
    @(negedge clk);
    check("t2_we", bus.write_en, 1); check("t2_rd", bus.wr_rd, 5); check("t2_data", bus.wr_data, 32'hBEEF);
    @(negedge clk); check("t2_we_off", bus.write_en, 0);

    // Bring the pointer back to 0 with one req2 transfer.
    step(); set_req(2, 4'd7, 32'h77); vld = 3'b100;
    step(); vld = '0;

    // All three held for six cycles: strict rotation, no bubbles.
    step(); set_req(0, 4'd8, 32'h80); set_req(1, 4'd9, 32'h90); set_req(2, 4'd10, 32'hA0); vld = 3'b111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t3_rdy", bus.req_ready, g3[c]);
      if (c > 0) check("t3_we", bus.write_en, 1);
      step();
    end
    vld = '0;
    @(negedge clk); check("t3_we_last", bus.write_en, 1);
    @(negedge clk); check("t3_we_off", bus.write_en, 0);

    // Move the pointer to 2 with one req1 transfer.
    step(); vld = 3'b010;
    step(); vld = '0;

    // Same destination from req0 and req2 with pointer at 2: req0 lands last.
    step(); set_req(0, 4'd3, 32'h1111); set_req(2, 4'd3, 32'h2222); vld = 3'b101;
    @(negedge clk); check("t4_rdy_a", bus.req_ready, 3'b100);
    step(); vld = 3'b001;
    @(negedge clk); check("t4_rdy_b", bus.req_ready, 3'b001);
    check("t4_first", bus.wr_data, 32'h2222);
    step(); vld = '0;
    @(negedge clk); @(negedge clk);
    check("t4_r3", sh_regs[3], 32'h1111);

    // Write to r0.
    step(); set_req(0, 4'd0, 32'h1234); vld = 3'b001;
    @(negedge clk); check("t6_rdy", bus.req_ready, 3'b001);
    step(); vld = '0;
    @(negedge clk);
`ifdef REG_ZERO_GUARD_EN
    check("t6_we", bus.write_en, 0);
    @(negedge clk); @(negedge clk); check("t6_r0", sh_regs[0], 0);
`else
    check("t6_we", bus.write_en, 1); check("t6_rd", bus.wr_rd, 0);
    @(negedge clk); @(negedge clk); check("t6_r0", sh_regs[0], 32'h1234);
`endif

    // Randomized traffic; a requester only changes its request after being granted.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (vld[i] && last_rdy[i]) vld[i] = 1'b0;
        if (!vld[i] && $urandom_range(0, 99) < 60) begin
          set_req(i, R'($urandom_range(0, NREGS - 1)), $urandom);
          vld[i] = 1'b1;
        end
      end
    end
    step(); vld = '0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    for (int r = 0; r < NREGS; r++) check("final_regs", sh_regs[r], m_regs[r]);

    // Reset landing on clear step 7 restarts the walk from index 0.
    step(); rst = 1'b0;
    step(); rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("t5a_rd", bus.wr_rd, k);
    end
    step(); rst = 1'b0;
    step(); rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NREGS; k++) begin
      @(negedge clk);
      check("t5b_we",   bus.write_en,   1);
      check("t5b_rd",   bus.wr_rd,      k);
      check("t5b_done", bus.clear_done, (k == NREGS - 1));
    end
    @(negedge clk);
    check("t5_done_hold", bus.clear_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
